// File: rtl/text_console_writer.sv
// text_console_writer
//   Write-side companion of the 80x30 text-mode framebuffer. Consumes a byte
//   stream, interprets printable ASCII plus LF/CR/BS/FF and drives write
//   port A of the text memory. Tracks the cursor and blanks the new line on
//   every line advance (and the whole screen on FF) so the pixel path always
//   sees consistent text.
//
//   Optional feature: define TEXT_CONSOLE_TAB_EN to enable 0x09 TAB handling
//   (blank-fill up to the next multiple-of-8 column). Without it, 0x09 is
//   dropped like any other unsupported control byte.
//
//   Ports
//     clk         system clock
//     rst_n       synchronous active-low reset
//     char_data   incoming character
//     char_valid  char_data valid
//     char_ready  writer can accept (transfer on valid && ready at posedge)
//     wea         text memory write enable (port A)
//     addra       text memory address = row*COLS + col
//     dina        text memory write data
//     cursor_col  current column 0..COLS-1
//     cursor_row  current row 0..ROWS-1
//     busy        high while a multi-cycle clear is in progress
module text_console_writer #(
    parameter int          COLS   = 80,
    parameter int          ROWS   = 30,
    parameter int          ADDR_W = 12,
    parameter logic [7:0]  BLANK  = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        char_data,
    input  logic              char_valid,
    output logic              char_ready,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [7:0]        dina,
    output logic [6:0]        cursor_col,
    output logic [4:0]        cursor_row,
    output logic              busy
);

    localparam int SCREEN = ROWS * COLS;

`ifdef TEXT_CONSOLE_TAB_EN
    typedef enum logic [1:0] {S_IDLE, S_CLR_LINE, S_CLR_SCREEN, S_TAB} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_CLR_LINE, S_CLR_SCREEN} state_t;
`endif

    state_t              state_q, state_d;
    logic [6:0]          col_q, col_d;
    logic [4:0]          row_q, row_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                wea_q, wea_d;
    logic [ADDR_W-1:0]   addra_q, addra_d;
    logic [7:0]          dina_q, dina_d;
    logic                busy_q, busy_d;
    logic                ready_q, ready_d;
    logic                clr_wr;     // a blank write belonging to a clear is issued
    logic [4:0]          nxt_row;
    logic                accept;
`ifdef TEXT_CONSOLE_TAB_EN
    logic                tab_go;
`endif

    // Row start address. For 80 columns use shift-and-add instead of a multiplier.
    function automatic logic [ADDR_W-1:0] row_base(input logic [4:0] row);
        logic [ADDR_W-1:0] r;
        r = ADDR_W'(row);
        if (COLS == 80) return (r << 6) + (r << 4);
        else            return ADDR_W'(32'(row) * COLS);
    endfunction

    assign nxt_row = (row_q == 5'(ROWS - 1)) ? 5'd0 : row_q + 5'd1;
    assign accept  = char_valid && ready_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        wea_d   = 1'b0;
        addra_d = addra_q;
        dina_d  = dina_q;
        clr_wr  = 1'b0;
`ifdef TEXT_CONSOLE_TAB_EN
        tab_go  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (char_data >= 8'h20 && char_data <= 8'h7E) begin
                        wea_d   = 1'b1;
                        addra_d = row_base(row_q) + ADDR_W'(col_q);
                        dina_d  = char_data;
                        if (col_q == 7'(COLS - 1)) begin
                            // char write occupies this edge; blanks start next one
                            col_d   = 7'd0;
                            row_d   = nxt_row;
                            cnt_d   = '0;
                            state_d = S_CLR_LINE;
                        end else begin
                            col_d = col_q + 7'd1;
                        end
                    end else begin
                        case (char_data)
                            8'h0A: begin
                                // first blank goes out immediately
                                col_d   = 7'd0;
                                row_d   = nxt_row;
                                wea_d   = 1'b1;
                                addra_d = row_base(nxt_row);
                                dina_d  = BLANK;
                                clr_wr  = 1'b1;
                                cnt_d   = ADDR_W'(1);
                                state_d = S_CLR_LINE;
                            end
                            8'h0D: col_d = 7'd0;
                            8'h08: begin
                                if (col_q != 7'd0) begin
                                    col_d   = col_q - 7'd1;
                                    wea_d   = 1'b1;
                                    addra_d = row_base(row_q) + ADDR_W'(col_q - 7'd1);
                                    dina_d  = BLANK;
                                end
                            end
                            8'h0C: begin
                                col_d   = 7'd0;
                                row_d   = 5'd0;
                                wea_d   = 1'b1;
                                addra_d = '0;
                                dina_d  = BLANK;
                                clr_wr  = 1'b1;
                                cnt_d   = ADDR_W'(1);
                                state_d = S_CLR_SCREEN;
                            end
`ifdef TEXT_CONSOLE_TAB_EN
                            8'h09: tab_go = 1'b1;
`endif
                            default: ;
                        endcase
                    end
                end
            end
            S_CLR_LINE: begin
                wea_d   = 1'b1;
                addra_d = row_base(row_q) + cnt_q;
                dina_d  = BLANK;
                clr_wr  = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(COLS - 1)) state_d = S_IDLE;
            end
            S_CLR_SCREEN: begin
                wea_d   = 1'b1;
                addra_d = cnt_q;
                dina_d  = BLANK;
                clr_wr  = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == ADDR_W'(SCREEN - 1)) state_d = S_IDLE;
            end
`ifdef TEXT_CONSOLE_TAB_EN
            S_TAB: tab_go = 1'b1;
`endif
            default: state_d = S_IDLE;
        endcase

`ifdef TEXT_CONSOLE_TAB_EN
        // One blank per cycle; stop after the cell just before a tab stop,
        // or after the last column, which then forces a line advance.
        if (tab_go) begin
            wea_d   = 1'b1;
            addra_d = row_base(row_q) + ADDR_W'(col_q);
            dina_d  = BLANK;
            if (col_q == 7'(COLS - 1)) begin
                col_d   = 7'd0;
                row_d   = nxt_row;
                cnt_d   = '0;
                state_d = S_CLR_LINE;
            end else begin
                col_d   = col_q + 7'd1;
                state_d = (col_q[2:0] == 3'b111) ? S_IDLE : S_TAB;
            end
        end
`endif
    end

    // Ready drops for the cycle carrying the last clear write, so it rises
    // only on the cycle after it.
    always_comb begin
        busy_d  = clr_wr || (state_d == S_CLR_LINE) || (state_d == S_CLR_SCREEN);
        ready_d = (state_d == S_IDLE) && !clr_wr;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            cnt_q   <= '0;
            wea_q   <= 1'b0;
            addra_q <= '0;
            dina_q  <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            wea_q   <= wea_d;
            addra_q <= addra_d;
            dina_q  <= dina_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign char_ready = ready_q;
    assign wea        = wea_q;
    assign addra      = addra_q;
    assign dina       = dina_q;
    assign cursor_col = col_q;
    assign cursor_row = row_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_text_console_writer.sv
module tb_text_console_writer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  char_data;
    logic        char_valid;
    logic        char_ready;
    logic        wea;
    logic [11:0] addra;
    logic [7:0]  dina;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    int checks = 0;
    int errors = 0;

    text_console_writer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .char_data  (char_data),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .wea        (wea),
        .addra      (addra),
        .dina       (dina),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a byte, hold it until accepted, return #1 after the accepting edge
    // (outputs then show the cycle following acceptance).
    task automatic send(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        char_data  = b;
        char_valid = 1'b1;
        while (!char_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", char_ready, 1);
        @(posedge clk);
        #1;
        char_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bad;
        int pulses;
        int expa;
        int n;

        rst_n      = 1'b0;
        char_data  = 8'h00;
        char_valid = 1'b0;

        // reset state
        repeat (3) step();
        check("rst_wea", wea, 0);
        check("rst_addra", addra, 0);
        check("rst_dina", dina, 0);
        check("rst_col", cursor_col, 0);
        check("rst_row", cursor_row, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", char_ready, 0);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", char_ready, 1);

        // 'A' at 0/0
        send(8'h41);
        check("A_wea", wea, 1);
        check("A_addra", addra, 0);
        check("A_dina", dina, 8'h41);
        check("A_col", cursor_col, 1);
        check("A_ready", char_ready, 1);
        step();
        check("A_wea_off", wea, 0);

        // CR back to col 0
        send(8'h0D);
        check("cr0_wea", wea, 0);
        check("cr0_col", cursor_col, 0);

        // 79 'x' back-to-back then 'y' at col 79
        bad = 0;
        for (int i = 0; i < 79; i++) begin
            send(8'h78);
            if (!(wea === 1'b1 && addra === 12'(i) && dina === 8'h78)) bad++;
        end
        check("x_run", bad, 0);
        send(8'h79);
        check("y_wea", wea, 1);
        check("y_addra", addra, 79);
        check("y_dina", dina, 8'h79);
        check("y_ready", char_ready, 0);
        check("y_col", cursor_col, 0);
        check("y_row", cursor_row, 1);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (!(wea === 1'b1 && addra === 12'(80 + i) && dina === 8'h20 &&
                  char_ready === 1'b0 && busy === 1'b1)) bad++;
        end
        check("line1_clear", bad, 0);
        step();
        check("line1_ready", char_ready, 1);
        check("line1_wea", wea, 0);
        check("line1_busy", busy, 0);
        check("line1_col", cursor_col, 0);
        check("line1_row", cursor_row, 1);

        // BS at col 0: no-op
        send(8'h08);
        check("bs0_wea", wea, 0);
        check("bs0_col", cursor_col, 0);
        check("bs0_row", cursor_row, 1);

        // LF from row 1: first blank at 160 on the accept cycle
        send(8'h0A);
        check("lf_wea", wea, 1);
        check("lf_addra", addra, 160);
        check("lf_busy", busy, 1);
        check("lf_row", cursor_row, 2);
        send(8'h0A);
        check("lf2_addra", addra, 240);

        // col 40 row 3, then CR
        for (int i = 0; i < 40; i++) send(8'h61);
        check("c40_col", cursor_col, 40);
        check("c40_row", cursor_row, 3);
        send(8'h0D);
        check("cr_wea", wea, 0);
        check("cr_col", cursor_col, 0);
        check("cr_row", cursor_row, 3);

        // move to 5/29
        for (int i = 0; i < 26; i++) send(8'h0A);
        for (int i = 0; i < 5; i++) send(8'h62);
        check("c529_col", cursor_col, 5);
        check("c529_row", cursor_row, 29);
        check("c529_addra", addra, 2324);

        // LF wraps to row 0
        send(8'h0A);
        check("wrap_first", addra, 0);
        pulses = (wea === 1'b1) ? 1 : 0;
        expa   = 1;
        bad    = 0;
        repeat (90) begin
            step();
            if (wea === 1'b1) begin
                if (addra !== 12'(expa) || dina !== 8'h20) bad++;
                expa++;
                pulses++;
            end
        end
        check("wrap_pulses", pulses, 80);
        check("wrap_addrs", bad, 0);
        check("wrap_col", cursor_col, 0);
        check("wrap_row", cursor_row, 0);
        check("wrap_ready", char_ready, 1);

        // BS at col 3 row 2
        send(8'h0A);
        send(8'h0A);
        send(8'h61);
        send(8'h62);
        send(8'h63);
        check("abc_addra", addra, 162);
        check("abc_col", cursor_col, 3);
        send(8'h08);
        check("bs_wea", wea, 1);
        check("bs_addra", addra, 162);
        check("bs_dina", dina, 8'h20);
        check("bs_col", cursor_col, 2);
        check("bs_row", cursor_row, 2);

        // FF: full screen clear
        send(8'h0C);
        check("ff_col", cursor_col, 0);
        check("ff_row", cursor_row, 0);
        bad = 0;
        for (int i = 0; i < 2400; i++) begin
            if (i > 0) step();
            if (!(wea === 1'b1 && addra === 12'(i) && dina === 8'h20 &&
                  busy === 1'b1 && char_ready === 1'b0)) bad++;
        end
        check("ff_seq", bad, 0);
        step();
        check("ff_ready", char_ready, 1);
        check("ff_busy", busy, 0);
        check("ff_wea", wea, 0);

        // reset in the middle of a screen clear
        send(8'h51);
        check("q_col", cursor_col, 1);
        send(8'h0C);
        n = 0;
        while (addra !== 12'd1000 && n < 2500) begin
            step();
            n++;
        end
        check("mid_ff_reached", addra, 1000);
        rst_n = 1'b0;
        step();
        check("abort_wea", wea, 0);
        check("abort_col", cursor_col, 0);
        check("abort_row", cursor_row, 0);
        check("abort_busy", busy, 0);
        rst_n = 1'b1;
        step();
        check("abort_ready", char_ready, 1);
        n = 0;
        repeat (20) begin
            step();
            if (wea === 1'b1) n++;
        end
        check("abort_no_writes", n, 0);

        // unsupported bytes are dropped
        send(8'h5A);
        check("z_addra", addra, 0);
        check("z_col", cursor_col, 1);
        send(8'h7F);
        check("del_wea", wea, 0);
        check("del_col", cursor_col, 1);
        send(8'h95);
        check("hi_wea", wea, 0);
        check("hi_col", cursor_col, 1);
        check("hi_ready", char_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
